seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle add/subtract unit. It processes WIDTH-bit operands CHUNK bits per clock through a ripple-carry slice, with a registered carry between slices.
- It is the sequential, wider successor to the 4-bit combinational full adder. It adds a subtract mode, signed-overflow detection and a start/busy/done handshake.
- It sits between register-file/control logic and the datapath wherever area matters more than single-cycle latency.

---
 rtl/seq_chunk_adder_pkg.sv | 40 ++++
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/seq_chunk_adder_chunk_adder.sv | 27 ++
 rtl/seq_chunk_adder.sv | 115 +++++++++++
 tb/tb_seq_chunk_adder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// adder_pkg: shared types and elaboration helpers for seq_chunk_adder.
//   state_e   - controller states (IDLE / BUSY / DONE)
//   clog2     - ceiling log2 usable in constant expressions
//   nchunk    - number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width - chunk counter width (never below 1 bit)
//   chunk_ok  - WIDTH must be a non-zero multiple of CHUNK
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A one-chunk configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: request/response bundle for seq_chunk_adder.
//   master : drives start, Sub, A, B, Cin; observes busy, done, Sum, Cout, Ovf
//   slave  : the adder side of the same signals
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output start, Sub, A, B, Cin,
    input  busy, done, Sum, Cout, Ovf
  );

  modport slave (
    input  start, Sub, A, B, Cin,
    output busy, done, Sum, Cout, Ovf
  );
endinterface

// File: rtl/seq_chunk_adder_chunk_adder.sv
// chunk_adder: CHUNK-bit combinational ripple-carry slice.
//   A, B : slice operands
//   Cin  : slice carry-in
//   Sum  : slice sum
//   Cout : slice carry-out
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Cin,
  output logic [CHUNK-1:0] Sum,
  output logic             Cout
);

  logic [CHUNK:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of seq_chunk_adder_if
//          start/Sub/A/B/Cin in; busy/done/Sum/Cout/Ovf out (all registered)
// Subtraction is A + ~B + ~Cin, so Cout reads as not-borrow and the same
// same-sign overflow rule covers both modes.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_chunk_adder_if.slave  bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e                       state_q;
  logic [NCHUNK-1:0][CHUNK-1:0] opa_q, opb_q, acc_q, acc_d;
  logic                         carry_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         busy_q, done_q;
  logic [WIDTH-1:0]             sum_q;
  logic                         cout_q, ovf_q;

  logic [CHUNK-1:0]             s_sum;
  logic                         s_cout;
  logic                         ovf_d;

  // Single slice, fed by whichever chunk the counter points at.
  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .A    (opa_q[cnt_q]),
    .B    (opb_q[cnt_q]),
    .Cin  (carry_q),
    .Sum  (s_sum),
    .Cout (s_cout)
  );

  // Accumulator with the current slice merged in; on the last chunk this is
  // the complete result, so Sum can load in the same edge.
  always_comb begin
    acc_d        = acc_q;
    acc_d[cnt_q] = s_sum;
  end

  // opb_q already holds ~B when subtracting.
  assign ovf_d = (opa_q[NCHUNK-1][CHUNK-1] == opb_q[NCHUNK-1][CHUNK-1]) &&
                 (acc_d[NCHUNK-1][CHUNK-1] != opa_q[NCHUNK-1][CHUNK-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            opa_q   <= bus.A;
            opb_q   <= bus.Sub ? ~bus.B : bus.B;
            carry_q <= bus.Cin ^ bus.Sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          carry_q <= s_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= s_cout;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_chunk_adder_if #(.WIDTH(16)) bus ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation and hold start for exactly one edge; returns at
  // edge+1 (first BUSY cycle).
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.Sub   = sub;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Cycles from the current sample point until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.Sub = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Cout, bus.Ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.Cout, bus.Ovf});
    end
    checks++;
    if (bus.Sum !== 16'h0000) begin
      errors++; $display("FAIL reset_sum got=%h exp=0000", bus.Sum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int n;
    int busy_cnt;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    busy_cnt = 0;
    n = 0;
    while (n < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      n++;
      if (bus.done === 1'b1) break;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", n); end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=4", busy_cnt); end
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf, bus.busy} !== {16'h0002, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result got=%h/%b/%b/%b exp=0002/0/0/0", bus.Sum, bus.Cout, bus.Ovf, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL basic_done_pulse got=%b exp=00", {bus.done, bus.busy});
    end
    // Carry-in on add
    issue(16'h000F, 16'h0000, 1'b1, 1'b0);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout} !== {16'h0010, 1'b0}) begin
      errors++; $display("FAIL add_cin got=%h/%b exp=0010/0", bus.Sum, bus.Cout);
    end
  endtask

  task automatic test_ripple();
    int n;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ripple got=%h/%b/%b exp=0000/1/0", bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_overflow();
    int n;
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL overflow got=%h/%b/%b exp=8000/0/1", bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_subtract();
    int n;
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow got=%h/%b/%b exp=fffe/0/0", bus.Sum, bus.Cout, bus.Ovf);
    end
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_ovf got=%h/%b/%b exp=7fff/1/1", bus.Sum, bus.Cout, bus.Ovf);
    end
    // Borrow-in: 0x0010 - 0x0001 - 1
    issue(16'h0010, 16'h0001, 1'b1, 1'b1);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf} !== {16'h000E, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_borrow_in got=%h/%b/%b exp=000e/1/0", bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // First op 3+4; start stays high through BUSY with new operands.
    bus.A = 16'h0003; bus.B = 16'h0004; bus.Cin = 1'b0; bus.Sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.A = 16'hAAAA; bus.B = 16'h1111;
    checks++;
    if ({bus.busy, bus.Sum} !== {1'b1, 16'h000E}) begin
      errors++; $display("FAIL hs_hold_old got=%b/%h exp=1/000e", bus.busy, bus.Sum);
    end
    wait_done(n);
    checks++;
    if ({n[7:0], bus.Sum} !== {8'd4, 16'h0007}) begin
      errors++; $display("FAIL hs_first got=%0d/%h exp=4/0007", n, bus.Sum);
    end
    // start still high in DONE -> second op accepted immediately.
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.Sum} !== {1'b1, 1'b0, 16'h0007}) begin
      errors++; $display("FAIL hs_second_start got=%b/%b/%h exp=1/0/0007", bus.busy, bus.done, bus.Sum);
    end
    wait_done(n);
    checks++;
    if ({n[7:0], bus.Sum, bus.Cout} !== {8'd4, 16'hBBBB, 1'b0}) begin
      errors++; $display("FAIL hs_second got=%0d/%h/%b exp=4/bbbb/0", n, bus.Sum, bus.Cout);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Sum, bus.Cout, bus.Ovf} !== 19'd0) begin
      errors++; $display("FAIL rst_mid got=%b/%b/%h/%b/%b exp=0/0/0000/0/0",
                         bus.busy, bus.done, bus.Sum, bus.Cout, bus.Ovf);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.busy, bus.Sum} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL rst_discard got=%b/%b/%h exp=0/0/0000", bus.done, bus.busy, bus.Sum);
    end
    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(n);
    checks++;
    if ({bus.Sum, bus.Cout, bus.Ovf} !== {16'h2345, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_after got=%h/%b/%b exp=2345/0/0", bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_add();
    test_ripple();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
